// File: rtl/region_footprint_prefetcher_pkg.sv
// Shared sizing, entry layouts and streamer state for the region footprint prefetcher.
// Every width in the design is derived from the constants below.
package region_pf_pkg;

  localparam int WIDTH                  = 64;
  localparam int BLOCK_BITS             = 6;
  localparam int REGION_BLOCKS          = 32;
  localparam int AT_ENTRIES             = 8;
  localparam int unsigned MIN_FOOTPRINT = 2;
  localparam int CNT_W                  = 16;

  localparam int OFF_BITS = $clog2(REGION_BLOCKS);
  localparam int AGE_BITS = $clog2(AT_ENTRIES);
  localparam int RGN_BITS = WIDTH - BLOCK_BITS - OFF_BITS;

  typedef logic [REGION_BLOCKS-1:0] fp_t;
  typedef logic [OFF_BITS-1:0]      off_t;
  typedef logic [RGN_BITS-1:0]      rgn_t;
  typedef logic [AGE_BITS-1:0]      age_t;
  typedef logic [AGE_BITS-1:0]      at_idx_t;

  typedef struct packed {
    logic valid;
    rgn_t region;
    off_t trig;
    fp_t  fp;
    age_t age;
  } at_entry_t;

  typedef struct packed {
    logic valid;
    fp_t  fp;
  } pht_entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } strm_state_e;

  function automatic int unsigned popcount(fp_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < REGION_BLOCKS; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pf_footprint_streamer.sv
// Walks a loaded footprint pattern lowest-offset first, presenting one block-aligned
// prefetch per cycle to the lower level; a new load preempts whatever is still pending.
module pf_footprint_streamer
  import region_pf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  rgn_t             load_region,
  input  fp_t              load_pattern,
  input  logic             lo_ready_i,
  output logic [WIDTH-1:0] lo_prefetch_address_o,
  output logic             lo_prefetch_valid_o,
  output logic             handshake
);

  strm_state_e state, state_nxt;
  fp_t         pattern, pattern_nxt;
  rgn_t        region, region_nxt;
  off_t        low_off;

  always_comb begin
    low_off = '0;
    for (int i = REGION_BLOCKS - 1; i >= 0; i--) begin
      if (pattern[i]) low_off = off_t'(i);
    end
  end

  assign lo_prefetch_valid_o   = (state == S_ISSUE);
  assign handshake             = lo_prefetch_valid_o & lo_ready_i;
  assign lo_prefetch_address_o = lo_prefetch_valid_o ?
                                 {region, low_off, {BLOCK_BITS{1'b0}}} : '0;

  // The handshake retires the presented bit first, so a same-cycle load still counts it
  always_comb begin
    pattern_nxt = pattern;
    region_nxt  = region;
    if (handshake) pattern_nxt = pattern & ~(fp_t'(1) << low_off);
    if (load && (load_pattern != '0)) begin
      pattern_nxt = load_pattern;
      region_nxt  = load_region;
    end
    state_nxt = (pattern_nxt != '0) ? S_ISSUE : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pattern <= '0;
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
    end
  end

  always_ff @(posedge clk) begin
    region <= region_nxt;
  end

endmodule

// File: rtl/region_footprint_prefetcher.sv
// Spatial footprint prefetcher: an accumulation table learns per-region block footprints,
// a trigger-offset-indexed history table replays them through the streamer on new triggers.
module region_footprint_prefetcher
  import region_pf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] up_address_i,
  input  logic             up_miss_i,
  input  logic             up_valid_i,
  input  logic             up_prefetched_i,
  input  logic             lo_ready_i,
  output logic [WIDTH-1:0] lo_prefetch_address_o,
  output logic             lo_prefetch_valid_o,
  output logic [CNT_W-1:0] pf_issued_count_o
);

  at_entry_t  at  [AT_ENTRIES];
  pht_entry_t pht [REGION_BLOCKS];

  off_t       acc_off;
  rgn_t       acc_rgn;
  fp_t        acc_onehot;
  logic       hit;
  at_idx_t    hit_idx;
  logic       have_free;
  at_idx_t    free_idx;
  at_idx_t    old_idx;
  at_idx_t    victim;
  age_t       ref_age;
  logic       trigger;
  logic       evict_wr;
  logic       load;
  fp_t        load_pattern;
  logic       handshake;
  logic [CNT_W-1:0] issued_cnt;
  logic       unused_inputs;

  // Prefetched-ness does not change training, and the byte offset never matters
  assign unused_inputs = ^{up_prefetched_i, up_address_i[BLOCK_BITS-1:0]};

  assign acc_off    = up_address_i[BLOCK_BITS +: OFF_BITS];
  assign acc_rgn    = up_address_i[WIDTH-1 -: RGN_BITS];
  assign acc_onehot = fp_t'(1) << acc_off;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < AT_ENTRIES; i++) begin
      if (!hit && at[i].valid && (at[i].region == acc_rgn)) begin
        hit     = 1'b1;
        hit_idx = at_idx_t'(i);
      end
    end
  end

  // Victim is the lowest free slot, otherwise the entry carrying the largest age
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    old_idx   = '0;
    for (int i = 0; i < AT_ENTRIES; i++) begin
      if (!have_free && !at[i].valid) begin
        have_free = 1'b1;
        free_idx  = at_idx_t'(i);
      end
    end
    for (int i = 1; i < AT_ENTRIES; i++) begin
      if (at[i].age > at[old_idx].age) old_idx = at_idx_t'(i);
    end
    victim  = have_free ? free_idx : old_idx;
    ref_age = at[victim].valid ? at[victim].age : '1;
  end

  assign trigger  = up_valid_i && up_miss_i && !hit;
  assign evict_wr = trigger && at[victim].valid &&
                    (popcount(at[victim].fp) >= MIN_FOOTPRINT);

  // History read is combinational off the current table, so it sees the pre-write value
  assign load         = trigger && pht[acc_off].valid;
  assign load_pattern = pht[acc_off].fp & ~acc_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AT_ENTRIES; i++) begin
        at[i].valid <= 1'b0;
        at[i].age   <= '0;
      end
    end else if (up_valid_i && hit) begin
      for (int i = 0; i < AT_ENTRIES; i++) begin
        if (at[i].valid && (at[i].age < at[hit_idx].age)) at[i].age <= at[i].age + 1'b1;
      end
      at[hit_idx].fp[acc_off] <= 1'b1;
      at[hit_idx].age         <= '0;
    end else if (trigger) begin
      for (int i = 0; i < AT_ENTRIES; i++) begin
        if (at[i].valid && (at[i].age < ref_age)) at[i].age <= at[i].age + 1'b1;
      end
      at[victim] <= '{valid: 1'b1, region: acc_rgn, trig: acc_off, fp: acc_onehot, age: '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGION_BLOCKS; i++) begin
        pht[i].valid <= 1'b0;
      end
    end else if (evict_wr) begin
      pht[at[victim].trig] <= '{valid: 1'b1, fp: at[victim].fp};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
    end else if (handshake && (issued_cnt != '1)) begin
      issued_cnt <= issued_cnt + 1'b1;
    end
  end

  assign pf_issued_count_o = issued_cnt;

  pf_footprint_streamer u_streamer (
    .clk                   (clk),
    .rst                   (rst),
    .load                  (load),
    .load_region           (acc_rgn),
    .load_pattern          (load_pattern),
    .lo_ready_i            (lo_ready_i),
    .lo_prefetch_address_o (lo_prefetch_address_o),
    .lo_prefetch_valid_o   (lo_prefetch_valid_o),
    .handshake             (handshake)
  );

endmodule
